// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bus of the PS/2 receive FIFO. The consumer is the master; the
// FIFO is the slave.
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic             err_clr;
  logic [7:0]       data;
  logic             ready;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             frame_err;

  modport master (
    output rd_en, err_clr,
    input  data, ready, level, overflow, frame_err
  );

  modport slave (
    input  rd_en, err_clr,
    output data, ready, level, overflow, frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver feeding a first-word-fall-through
// scan-code FIFO, with sticky overflow and framing-error flags.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_rx_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, RX = 1'b1} state_t;

  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic             clk_s1_q, clk_s2_q, clk_s3_q, data_s1_q, data_s2_q;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [10:0]      shift_q, shift_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, frame_err_q;

  logic             fe_s, bit_s, stop_s, frame_ok_s, timeout_s;
  logic             push_s, ferr_set_s, pop_s, full_s, write_s, ovf_set_s;
  logic [10:0]      frame_s;

  // Idle level of the PS/2 lines is 1, so the synchronisers reset high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  assign fe_s       = clk_s3_q & ~clk_s2_q;
  assign bit_s      = data_s2_q;
  assign frame_s    = {bit_s, shift_q[10:1]};
  assign stop_s     = fe_s && (state_q == RX) && (cnt_q == 4'd10);
  assign frame_ok_s = !frame_s[0] && frame_s[10] && odd_parity_ok(frame_s[9:1]);
  assign timeout_s  = (state_q == RX) && !fe_s && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      shift_q <= 11'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fe_s && !bit_s) begin
          state_d = RX;
          cnt_d   = 4'd1;
          shift_d = {bit_s, shift_q[10:1]};
        end else begin
          cnt_d = 4'd0;
        end
      end
      RX: begin
        if (fe_s) begin
          timer_d = '0;
          shift_d = {bit_s, shift_q[10:1]};
          if (cnt_q == 4'd10) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (timeout_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    push_s     = 1'b0;
    ferr_set_s = 1'b0;
    case (state_q)
      IDLE: ferr_set_s = fe_s && bit_s;
      RX: begin
        push_s     = stop_s && frame_ok_s;
        ferr_set_s = (stop_s && !frame_ok_s) || timeout_s;
      end
      default: begin
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
      end
    endcase
  end

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign pop_s     = bus.rd_en && (level_q != '0);
  assign full_s    = (level_q == LVL_W'(FIFO_DEPTH));
  assign write_s   = push_s && (!full_s || pop_s);
  assign ovf_set_s = push_s && full_s && !pop_s;

  always_comb begin
    if (write_s && !pop_s) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_s && !write_s) begin
      level_d = level_q - LVL_W'(1);
    end else begin
      level_d = level_q;
    end
  end

  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_q[wr_ptr_q] <= frame_s[8:1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (write_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q     <= level_d;
      overflow_q  <= ovf_set_s  | (overflow_q  & ~bus.err_clr);
      frame_err_q <= ferr_set_s | (frame_err_q & ~bus.err_clr);
    end
  end

  assign bus.data      = (level_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.ready     = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames are bit-banged at 20 clk cycles
// per phase half and outputs are compared on the falling clk edge.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TMO   = 200;

  logic clk = 1'b0;
  logic reset, ps2_clk, ps2_data;
  int   checks = 0;
  int   failures = 0;

  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // One PS/2 bit; pop pulses rd_en in the cycle the falling edge is detected.
  task automatic send_bit(input logic b, input logic pop);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    bus.rd_en = pop;
    @(negedge clk);
    bus.rd_en = 1'b0;
    repeat (17) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] d, input logic p, input int n, input logic pop_last);
    logic [10:0] f;
    f = {1'b1, p, d, 1'b0};
    for (int i = 0; i < n; i++) send_bit(f[i], pop_last && (i == 10));
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(d, good_par(d), 11, 1'b0);
  endtask

  task automatic pop;
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic clr_err;
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data"},  bus.data, 32'h00);
    check({tag, "_ready"}, bus.ready, 32'd0);
    check({tag, "_level"}, bus.level, 32'd0);
    check({tag, "_ovf"},   bus.overflow, 32'd0);
    check({tag, "_ferr"},  bus.frame_err, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst");

    // 1: single frame 0x1C, push latency measured from the stop-bit edge
    send_bits(8'h1C, 1'b0, 10, 1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    check("t1_ready", bus.ready, 32'd1);
    check("t1_data",  bus.data, 32'h1C);
    check("t1_level", bus.level, 32'd1);
    check("t1_ovf",   bus.overflow, 32'd0);
    check("t1_ferr",  bus.frame_err, 32'd0);
    repeat (16) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    pop();
    check("t1_pop_ready", bus.ready, 32'd0);
    check("t1_pop_data",  bus.data, 32'h00);
    pop();
    check("t1_empty_pop_level", bus.level, 32'd0);
    check("t1_empty_pop_ferr",  bus.frame_err, 32'd0);

    // 2: two queued frames, FWFT order
    send_frame(8'hF0);
    send_frame(8'h1C);
    check("t2_level", bus.level, 32'd2);
    check("t2_data",  bus.data, 32'hF0);
    pop();
    check("t2_data_after_pop", bus.data, 32'h1C);
    check("t2_level_after_pop", bus.level, 32'd1);

    // 3: bad parity sets frame_err and leaves the FIFO alone
    send_bits(8'h1C, 1'b1, 11, 1'b0);
    check("t3_ferr",  bus.frame_err, 32'd1);
    check("t3_level", bus.level, 32'd1);
    clr_err();
    check("t3_ferr_clr", bus.frame_err, 32'd0);
    check("t3_data_kept", bus.data, 32'h1C);
    pop();
    check("t3_empty", bus.ready, 32'd0);

    // 4: overflow on the 9th byte
    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    check("t4_level", bus.level, 32'd8);
    check("t4_ovf",   bus.overflow, 32'd1);
    check("t4_data",  bus.data, 32'h01);
    check("t4_ferr",  bus.frame_err, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t4_pop%0d", i), bus.data, 32'(i));
      pop();
    end
    check("t4_drained", bus.level, 32'd0);
    clr_err();
    check("t4_ovf_clr", bus.overflow, 32'd0);

    // 5: push into a full FIFO with a simultaneous pop
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i));
    check("t5_full", bus.level, 32'd8);
    send_bits(8'h55, good_par(8'h55), 11, 1'b1);
    check("t5_level", bus.level, 32'd8);
    check("t5_ovf",   bus.overflow, 32'd0);
    check("t5_head",  bus.data, 32'h12);
    for (int i = 0; i < 7; i++) pop();
    check("t5_last",  bus.data, 32'h55);
    check("t5_last_level", bus.level, 32'd1);
    pop();
    check("t5_empty", bus.level, 32'd0);

    // 6a: timeout on a partial frame, then recovery
    send_bits(8'h2A, good_par(8'h2A), 5, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    check("t6_tmo_ferr",  bus.frame_err, 32'd1);
    check("t6_tmo_level", bus.level, 32'd0);
    clr_err();
    send_frame(8'h2A);
    check("t6_rx_data",  bus.data, 32'h2A);
    check("t6_rx_level", bus.level, 32'd1);
    check("t6_rx_ferr",  bus.frame_err, 32'd0);
    pop();

    // 6b: reset in the middle of a frame
    send_frame(8'h77);
    send_bits(8'h2A, good_par(8'h2A), 6, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state("t6_rst");
    send_frame(8'h2A);
    check("t6_rst_data",  bus.data, 32'h2A);
    check("t6_rst_level", bus.level, 32'd1);
    check("t6_rst_ferr",  bus.frame_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
